// File: rtl/alu_issue_unit.sv
// alu_issue_unit: single-issue ALU front end. Accepts one instruction at a
// time, reads two operands from an external register file (with a bypass
// from the write port landing on the same edge), executes in one cycle for
// ALU ops or four shift-add cycles for MUL, then writes the result back.
//
// Handshake: in_valid/in_ready follow strict valid/ready semantics. An
// instruction is accepted on a rising edge where in_valid && in_ready; the
// fields are sampled only on that edge. in_valid while in_ready=0 has no
// effect, and the offering side may change any input freely at that time.
module alu_issue_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  output logic [ADDR_W-1:0] read_addr1,
  output logic [ADDR_W-1:0] read_addr2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [1:0]        dbg_state
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t              state_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   opa_q;    // rs1 operand; multiplicand shifts left per MUL cycle
  logic [DATA_W-1:0]   opb_q;    // rs2 operand; multiplier shifts right per MUL cycle
  logic [DATA_W-1:0]   acc_q;    // MUL partial-sum accumulator
  logic [1:0]          cnt_q;    // MUL digit counter
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                fz_q;
  logic                fc_q;

  logic                accept;
  logic [DATA_W-1:0]   src1_d;
  logic [DATA_W-1:0]   src2_d;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W-1:0]   mul_digit;
  logic [DATA_W-1:0]   mul_step;

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_WB);
  assign accept     = in_valid && in_ready;
  assign read_addr1 = in_rs1;
  assign read_addr2 = in_rs2;
  assign we         = we_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign flag_zero  = fz_q;
  assign flag_carry = fc_q;
  assign dbg_state  = state_q;

  // Operand select: the file write on this edge is not yet visible on
  // read_data, so forward write_data when it targets the source register.
  always_comb begin
    src1_d = read_data1;
    src2_d = read_data2;
    if (we_q && (waddr_q == in_rs1)) src1_d = wdata_q;
    if (we_q && (waddr_q == in_rs2)) src2_d = wdata_q;
  end

  // Single-cycle ALU result and carry for the EXEC state.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum_ext   = {1'b0, opa_q} + {1'b0, opb_q};
    case (op_q)
      OP_ADD: {alu_carry, alu_res} = sum_ext;
      OP_SUB: begin
        alu_res   = opa_q - opb_q;
        alu_carry = (opa_q < opb_q);
      end
      OP_AND: alu_res = opa_q & opb_q;
      OP_OR:  alu_res = opa_q | opb_q;
      OP_XOR: alu_res = opa_q ^ opb_q;
      OP_SHL: begin
        alu_res   = {opa_q[DATA_W-2:0], 1'b0};
        alu_carry = opa_q[DATA_W-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, opa_q[DATA_W-1:1]};
        alu_carry = opa_q[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // One shift-add step: accumulate multiplicand times the low 4-bit digit.
  always_comb begin
    mul_digit = DATA_W'(opb_q[3:0]);
    mul_step  = acc_q + (opa_q * mul_digit);
  end

  // Control FSM with registered write-port and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WB: begin
          we_q <= 1'b0;
          if (accept) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            opa_q <= src1_d;
            opb_q <= src2_d;
            acc_q <= '0;
            cnt_q <= '0;
            state_q <= (in_op == OP_MUL) ? S_MUL : S_EXEC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          we_q    <= 1'b1;
          waddr_q <= rd_q;
          wdata_q <= alu_res;
          fz_q    <= (alu_res == '0);
          fc_q    <= alu_carry;
          state_q <= S_WB;
        end
        S_MUL: begin
          acc_q <= mul_step;
          opa_q <= opa_q << 4;
          opb_q <= opb_q >> 4;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we_q    <= 1'b1;
            waddr_q <= rd_q;
            wdata_q <= mul_step;
            fz_q    <= (mul_step == '0);
            fc_q    <= 1'b0;
            state_q <= S_WB;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: external register file, arithmetic reference
// model with a golden register array, and an expected-write queue.
module tb_alu_issue_unit;

  localparam int DW = 16;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [AW-1:0] read_addr1, read_addr2;
  logic [DW-1:0] read_data1, read_data2;
  logic          we;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          flag_zero, flag_carry;
  logic [1:0]    dbg_state;

  alu_issue_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2),
    .we(we), .write_addr(write_addr), .write_data(write_data),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .dbg_state(dbg_state)
  );

  // register file (environment) with a preload port usable during reset
  logic [DW-1:0] rf [16];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (we) rf[write_addr] <= write_data;
  end
  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];

  // reference model state and scoreboard
  logic [DW-1:0] gold [16];
  logic [DW+AW+1:0] exp_q [$];   // {carry, zero, addr, data}
  int total = 0;
  int bad = 0;
  logic [AW-1:0] last_rd = '0;
  logic [DW-1:0] last_res = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result and carry straight from the instruction definitions.
  task automatic model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output logic [DW-1:0] res, output logic c);
    int unsigned ua, ub, full;
    ua = a; ub = b; full = 0; c = 1'b0;
    case (op)
      3'd0: begin full = ua + ub; c = (full > 32'hFFFF); end
      3'd1: begin full = ua - ub; c = (ua < ub); end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: begin full = ua * 2; c = (ua >= 32'h8000); end
      3'd6: begin full = ua / 2; c = (ua % 2) == 1; end
      default: full = (ua * ub);
    endcase
    res = full[DW-1:0];
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] v);
    pl_en = 1'b1; pl_addr = AW'(idx); pl_data = v;
    gold[idx] = v;
    step();
    pl_en = 1'b0;
  endtask

  // Issue one instruction (unit must be ready now) and follow it to WB,
  // offering junk with in_valid=1 while the unit is busy.
  task automatic run_instr(input logic [2:0] op, input int rd, input int rs1, input int rs2);
    logic [DW-1:0] res, a, b;
    logic c;
    logic [DW+AW+1:0] e;
    int n;
    chk("ready_before_issue", in_ready, 1);
    in_valid = 1'b1; in_op = op;
    in_rd = AW'(rd); in_rs1 = AW'(rs1); in_rs2 = AW'(rs2);
    #1;
    chk("read_addr1", read_addr1, rs1);
    chk("read_addr2", read_addr2, rs2);
    a = gold[rs1]; b = gold[rs2];
    model(op, a, b, res, c);
    gold[rd] = res;
    exp_q.push_back({c, (res == '0), AW'(rd), res});
    step();
    n = (op == 3'd7) ? 4 : 1;
    for (int i = 0; i < n; i++) begin
      chk("busy_ready", in_ready, 0);
      chk("busy_we", we, 0);
      in_valid = 1'b1;
      in_op = 3'($urandom_range(0, 7));
      in_rd = AW'($urandom_range(0, 15));
      in_rs1 = AW'($urandom_range(0, 15));
      in_rs2 = AW'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    chk("wb_we", we, 1);
    chk("wb_ready", in_ready, 1);
    chk("wb_addr", write_addr, e[DW+AW-1:DW]);
    chk("wb_data", write_data, e[DW-1:0]);
    chk("wb_zero", flag_zero, e[DW+AW]);
    chk("wb_carry", flag_carry, e[DW+AW+1]);
    last_rd = e[DW+AW-1:DW];
    last_res = e[DW-1:0];
  endtask

  task automatic idle_cycle();
    step();
    chk("idle_we", we, 0);
    chk("idle_addr_hold", write_addr, last_rd);
    chk("idle_data_hold", write_data, last_res);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] keep13;
    // reset with register-file preload
    for (int i = 0; i < 16; i++) gold[i] = '0;
    step();
    chk("rst_ready", in_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_zero", flag_zero, 0);
    chk("rst_carry", flag_carry, 0);
    for (int i = 0; i < 16; i++) preload(i, DW'($urandom));
    preload(0, 16'hAAAA);
    preload(1, 16'h5555);
    preload(5, 16'hFFFF);
    preload(6, 16'h0001);
    preload(9, 16'h0012);
    preload(10, 16'h0034);
    preload(13, 16'h1234);
    rst_n = 1'b1;
    step();

    // directed sequence
    run_instr(3'd0, 3, 0, 1);    // ADD r3 = FFFF
    run_instr(3'd1, 4, 3, 1);    // SUB r4 in WB, bypass of r3
    run_instr(3'd0, 7, 5, 6);    // ADD r7 = 0000, zero, carry
    idle_cycle();
    run_instr(3'd1, 8, 6, 5);    // SUB r8 = 0002, borrow
    run_instr(3'd7, 11, 9, 10);  // MUL r11 = 03A8
    run_instr(3'd6, 12, 6, 2);   // SHR1 r12 = 0000, carry
    idle_cycle();
    chk("r3_val", rf[3], 16'hFFFF);
    chk("r4_val", rf[4], 16'hAAAA);
    chk("r7_val", rf[7], 16'h0000);
    chk("r8_val", rf[8], 16'h0002);
    chk("r11_val", rf[11], 16'h03A8);
    chk("r12_val", rf[12], 16'h0000);

    // reset in the second MUL cycle drops the instruction
    keep13 = rf[13];
    in_valid = 1'b1; in_op = 3'd7; in_rd = 4'd13; in_rs1 = 4'd9; in_rs2 = 4'd10;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_we", we, 0);
    chk("mrst_addr", write_addr, 0);
    chk("mrst_data", write_data, 0);
    chk("mrst_zero", flag_zero, 0);
    chk("mrst_carry", flag_carry, 0);
    step();
    step();
    rst_n = 1'b1;
    chk("mrst_ready_after", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst_no_write", we, 0);
    end
    chk("mrst_r13_kept", rf[13], keep13);
    last_rd = '0;
    last_res = '0;

    // randomized instructions against the model
    for (int k = 0; k < 30; k++) begin
      run_instr(3'($urandom_range(0, 7)), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    step();
    for (int i = 0; i < 16; i++) chk($sformatf("rf_final_%0d", i), rf[i], gold[i]);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // safety bound on run time
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
